rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 29 ++
 rtl/rom_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rom_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two requesters (ID checker, password checker),
// the shared ROM and rom_arbiter.
interface rom_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 24
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] ROM_data;
    logic [ADDR_W-1:0] ROM_addr;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, req1, addr0, addr1, ROM_data,
        input  ROM_addr, gnt0, gnt1, done0, done1, rdata, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, ROM_data,
        output ROM_addr, gnt0, gnt1, done0, done1, rdata, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for a shared ROM with a fixed LAT-cycle read latency.
// Macro ROMARB_RR_EN selects round-robin; undefined gives requester 0 fixed priority.
module rom_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 24,
    parameter int LAT    = 2
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CATCH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              win_q;
    logic              win_d;
    logic              last_q;
    logic              last_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              gnt0_q;
    logic              gnt0_d;
    logic              gnt1_q;
    logic              gnt1_d;
    logic              done0_q;
    logic              done0_d;
    logic              done1_q;
    logic              done1_d;
    logic              busy_q;
    logic              busy_d;
    logic              any_req_s;
    logic              arb_win_s;

    // With nobody requesting the result is never used; it simply holds the pointer.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        logic w;
`ifdef ROMARB_RR_EN
        if (r0 && r1) begin
            w = ~last;
        end else if (r1) begin
            w = 1'b1;
        end else if (r0) begin
            w = 1'b0;
        end else begin
            w = last;
        end
`else
        if (r0) begin
            w = 1'b0;
        end else if (r1) begin
            w = 1'b1;
        end else begin
            w = last;
        end
`endif
        return w;
    endfunction

    assign any_req_s = bus.req0 | bus.req1;
    assign arb_win_s = pick_winner(bus.req0, bus.req1, last_q);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CATCH;
                end else begin
                    state_d = WAIT;
                end
            end
            CATCH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; pulses default low, data holds.
    always_comb begin
        cnt_d      = cnt_q;
        win_d      = win_q;
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    win_d      = arb_win_s;
                    rom_addr_d = arb_win_s ? bus.addr1 : bus.addr0;
                    gnt0_d     = ~arb_win_s;
                    gnt1_d     = arb_win_s;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
            end
            CATCH: begin
                rdata_d = bus.ROM_data;
                done0_d = ~win_q;
                done1_d = win_q;
            end
            DONE: begin
                last_d = win_q;
            end
            default: begin
                cnt_d      = 4'd0;
                win_d      = 1'b0;
                last_d     = 1'b1;
                rom_addr_d = '0;
                rdata_d    = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Registered outputs and access bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 4'd0;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ROM_addr = rom_addr_q;
    assign bus.rdata    = rdata_q;
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter (LAT=2); honours ROMARB_RR_EN.
module tb_rom_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 24;
    localparam int LAT    = 2;
    localparam int PER    = LAT + 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [DATA_W-1:0] rom [0:31];

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.ROM_data = rom[bus.ROM_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] p;
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = 5'd0; bus.addr1 = 5'd0;
        tick(); tick();
        p = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", p); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.ROM_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h expected 00", bus.ROM_addr); end
        checks++; if (bus.rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 000000", bus.rdata); end
        rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_access();
        logic [3:0] p, ep;
        bus.req1 = 1'b1; bus.addr1 = 5'd5;
        for (int c = 0; c <= LAT + 2; c++) begin
            tick();
            p  = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            ep = {1'b0, (c == 0), 1'b0, (c == LAT + 1)};
            checks++; if (p !== ep) begin errors++; $display("FAIL single_pulses c=%0d: got %b expected %b", c, p, ep); end
            checks++; if (bus.busy !== (c <= LAT + 1)) begin errors++; $display("FAIL single_busy c=%0d: got %b expected %b", c, bus.busy, (c <= LAT + 1)); end
            if (c == 0) begin
                checks++; if (bus.ROM_addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %h expected 05", bus.ROM_addr); end
            end
            if (c == LAT + 1) begin
                checks++; if (bus.rdata !== 24'h123456) begin errors++; $display("FAIL single_rdata: got %h expected 123456", bus.rdata); end
                bus.req1 = 1'b0;
            end
        end
        checks++; if (bus.rdata !== 24'h123456) begin errors++; $display("FAIL single_rdata_hold: got %h expected 123456", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p, ep;
        int ph;
        bus.req1 = 1'b1; bus.addr1 = 5'd5;
        for (int c = 0; c <= 2 * PER; c++) begin
            tick();
            ph = c % PER;
            p  = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            ep = {1'b0, (ph == 0) && (c < 2 * PER), 1'b0, (ph == LAT + 1)};
            checks++; if (p !== ep) begin errors++; $display("FAIL b2b_pulses c=%0d: got %b expected %b", c, p, ep); end
            if (c == PER + LAT + 1) begin
                bus.req1 = 1'b0;
            end
        end
    endtask

    task automatic test_drop_in_wait();
        logic [3:0] p, ep;
        bus.req0 = 1'b1; bus.addr0 = 5'd7;
        tick();
        p = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
        checks++; if (p !== 4'b1000) begin errors++; $display("FAIL drop_gnt: got %b expected 1000", p); end
        checks++; if (bus.ROM_addr !== 5'd7) begin errors++; $display("FAIL drop_addr: got %h expected 07", bus.ROM_addr); end
        bus.req0 = 1'b0; bus.addr0 = 5'd0;
        for (int c = 1; c <= LAT + 4; c++) begin
            tick();
            p  = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            ep = {1'b0, 1'b0, (c == LAT + 1), 1'b0};
            checks++; if (p !== ep) begin errors++; $display("FAIL drop_pulses c=%0d: got %b expected %b", c, p, ep); end
            checks++; if (bus.busy !== (c <= LAT + 1)) begin errors++; $display("FAIL drop_busy c=%0d: got %b expected %b", c, bus.busy, (c <= LAT + 1)); end
            if (c == LAT + 1) begin
                checks++; if (bus.rdata !== 24'hABCDEF) begin errors++; $display("FAIL drop_rdata: got %h expected abcdef", bus.rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] p, ep;
        bus.req0 = 1'b1; bus.addr0 = 5'd4;
        tick();
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b expected 1", bus.gnt0); end
        tick();
        #2 rst = 1'b0;
        #1;
        p = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
        checks++; if ({p, bus.busy} !== 5'b0) begin errors++; $display("FAIL rstmid_async: got %b expected 00000", {p, bus.busy}); end
        checks++; if (bus.ROM_addr !== 5'd0) begin errors++; $display("FAIL rstmid_addr: got %h expected 00", bus.ROM_addr); end
        for (int c = 0; c < LAT + 1; c++) begin
            tick();
            checks++; if (bus.done0 !== 1'b0) begin errors++; $display("FAIL rstmid_nodone c=%0d: got %b expected 0", c, bus.done0); end
        end
        rst = 1'b1;
        for (int c = 0; c <= LAT + 2; c++) begin
            tick();
            p  = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            ep = {(c == 0), 1'b0, (c == LAT + 1), 1'b0};
            checks++; if (p !== ep) begin errors++; $display("FAIL rstmid_retry c=%0d: got %b expected %b", c, p, ep); end
            if (c == LAT + 1) begin
                checks++; if (bus.rdata !== 24'h4A4A4A) begin errors++; $display("FAIL rstmid_rdata: got %h expected 4a4a4a", bus.rdata); end
                bus.req0 = 1'b0;
            end
        end
    endtask

    task automatic test_both_requesting();
        logic [3:0] p, ep;
        int k, ph, w;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 5'd2; bus.addr1 = 5'd3;
        for (int c = 0; c < 4 * PER; c++) begin
            tick();
            k  = c / PER;
            ph = c % PER;
`ifdef ROMARB_RR_EN
            w = k % 2;
`else
            w = 0;
`endif
            p  = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            ep = {(ph == 0) && (w == 0), (ph == 0) && (w == 1),
                  (ph == LAT + 1) && (w == 0), (ph == LAT + 1) && (w == 1)};
            checks++; if (p !== ep) begin errors++; $display("FAIL both_pulses c=%0d: got %b expected %b", c, p, ep); end
            if (ph == 0) begin
                checks++; if (bus.ROM_addr !== ((w == 1) ? 5'd3 : 5'd2)) begin errors++; $display("FAIL both_addr k=%0d: got %h expected %h", k, bus.ROM_addr, (w == 1) ? 5'd3 : 5'd2); end
            end
            if (ph == LAT + 1) begin
                checks++; if (bus.rdata !== rom[(w == 1) ? 3 : 2]) begin errors++; $display("FAIL both_rdata k=%0d: got %h expected %h", k, bus.rdata, rom[(w == 1) ? 3 : 2]); end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL both_idle: got %b expected 0", bus.busy); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i] = 24'(i) * 24'h010101;
        end
        rom[2] = 24'h222222;
        rom[3] = 24'h333333;
        rom[4] = 24'h4A4A4A;
        rom[5] = 24'h123456;
        rom[7] = 24'hABCDEF;

        test_reset();
        test_single_access();
        test_back_to_back();
        test_drop_in_wait();
        test_reset_mid_access();
        test_both_requesting();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
